a2d_spi_resp: RTL and testbench

//  SPI responder for the 8-channel 12-bit A2D converter, the far end of the A2D_intf SPI link.

---
 rtl/a2d_spi_resp.sv | 151 +++++++++++++++
 tb/tb_a2d_spi_resp.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/a2d_spi_resp.sv
// SPI responder for the 8-channel A2D link: takes 16-bit commands on MOSI and returns the
// channel value selected by the previous command on MISO.
module a2d_spi_resp #(
    parameter int FRAME_W = 16,
    parameter int DATA_W  = 12,
    parameter int NUM_CH  = 8,
    parameter int CH_W    = $clog2(NUM_CH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              SS_n,
    input  logic              SCLK,
    input  logic              MOSI,
    output logic              MISO,
    input  logic              ch_wr,
    input  logic [CH_W-1:0]   ch_addr,
    input  logic [DATA_W-1:0] ch_wdata,
    output logic              cmd_vld,
    output logic [CH_W-1:0]   cmd_ch,
    output logic              frm_err
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    logic ss_s1_q, ss_s2_q, ss_prev_q;
    logic sclk_s1_q, sclk_s2_q, sclk_prev_q;
    logic mosi_s1_q, mosi_s2_q;

    logic [1:0]         state_q, state_d;
    logic [4:0]         bit_cnt_q, bit_cnt_d;
    logic [FRAME_W-1:0] tx_shft_q, tx_shft_d;
    logic [FRAME_W-1:0] rx_shft_q, rx_shft_d;
    logic [CH_W-1:0]    ch_ptr_q, ch_ptr_d;
    logic [CH_W-1:0]    cmd_ch_q, cmd_ch_d;
    logic               cmd_vld_q, cmd_vld_d;
    logic               frm_err_q, frm_err_d;
    logic               pend_q, pend_d;
    logic [DATA_W-1:0]  chan_q [NUM_CH];
    logic [DATA_W-1:0]  chan_d [NUM_CH];

    logic ss_fall, ss_rise, sclk_rise;

    // Synchronizers are left out of reset so a reset with SS_n held low cannot fake a fall edge.
    always_ff @(posedge clk) begin
        ss_s1_q     <= SS_n;
        ss_s2_q     <= ss_s1_q;
        ss_prev_q   <= ss_s2_q;
        sclk_s1_q   <= SCLK;
        sclk_s2_q   <= sclk_s1_q;
        sclk_prev_q <= sclk_s2_q;
        mosi_s1_q   <= MOSI;
        mosi_s2_q   <= mosi_s1_q;
    end

    assign ss_fall   = ss_prev_q & ~ss_s2_q;
    assign ss_rise   = ~ss_prev_q & ss_s2_q;
    assign sclk_rise = ~sclk_prev_q & sclk_s2_q;

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        tx_shft_d = tx_shft_q;
        rx_shft_d = rx_shft_q;
        ch_ptr_d  = ch_ptr_q;
        cmd_ch_d  = cmd_ch_q;
        cmd_vld_d = 1'b0;
        frm_err_d = 1'b0;
        pend_d    = pend_q;
        chan_d    = chan_q;

        if (ch_wr) begin
            chan_d[ch_addr] = ch_wdata;
        end

        case (state_q)
            IDLE: begin
                pend_d = 1'b0;
                if (ss_fall || (pend_q && !ss_s2_q)) begin
                    tx_shft_d = {{(FRAME_W-DATA_W){1'b0}}, chan_q[ch_ptr_q]};
                    bit_cnt_d = 5'd0;
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                // A coincident SS_n rise still takes this last SCLK shift before DONE.
                if (sclk_rise) begin
                    rx_shft_d = {rx_shft_q[FRAME_W-2:0], mosi_s2_q};
                    tx_shft_d = {tx_shft_q[FRAME_W-2:0], 1'b0};
                    if (bit_cnt_q != 5'd31) begin
                        bit_cnt_d = bit_cnt_q + 5'd1;
                    end
                end
                if (ss_rise) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
                if (ss_fall) begin
                    pend_d = 1'b1;
                end
                if (bit_cnt_q == 5'(FRAME_W) && rx_shft_q[FRAME_W-1 -: 2] == 2'b00) begin
                    cmd_vld_d = 1'b1;
                    cmd_ch_d  = rx_shft_q[FRAME_W-3 -: CH_W];
                    ch_ptr_d  = rx_shft_q[FRAME_W-3 -: CH_W];
                end else begin
                    frm_err_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            bit_cnt_q <= 5'd0;
            tx_shft_q <= '0;
            rx_shft_q <= '0;
            ch_ptr_q  <= '0;
            cmd_ch_q  <= '0;
            cmd_vld_q <= 1'b0;
            frm_err_q <= 1'b0;
            pend_q    <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                chan_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            tx_shft_q <= tx_shft_d;
            rx_shft_q <= rx_shft_d;
            ch_ptr_q  <= ch_ptr_d;
            cmd_ch_q  <= cmd_ch_d;
            cmd_vld_q <= cmd_vld_d;
            frm_err_q <= frm_err_d;
            pend_q    <= pend_d;
            chan_q    <= chan_d;
        end
    end

    assign MISO    = ~ss_s2_q & tx_shft_q[FRAME_W-1];
    assign cmd_vld = cmd_vld_q;
    assign cmd_ch  = cmd_ch_q;
    assign frm_err = frm_err_q;

endmodule

// File: tb/tb_a2d_spi_resp.sv
// Bench for a2d_spi_resp: drives SPI frames at clk/16 and checks replies and pulses
// against a channel-file / pointer model.
module tb_a2d_spi_resp;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        SS_n = 1'b1;
    logic        SCLK = 1'b1;
    logic        MOSI = 1'b0;
    logic        MISO;
    logic        ch_wr = 1'b0;
    logic [2:0]  ch_addr = 3'd0;
    logic [11:0] ch_wdata = 12'd0;
    logic        cmd_vld;
    logic [2:0]  cmd_ch;
    logic        frm_err;

    int vectors = 0;
    int miscompares = 0;
    int vld_cnt = 0;
    int err_cnt = 0;

    logic [11:0] chan_m [8];
    logic [2:0]  ptr_m;
    logic [2:0]  cmd_ch_m;

    a2d_spi_resp dut (
        .clk(clk), .rst_n(rst_n), .SS_n(SS_n), .SCLK(SCLK), .MOSI(MOSI), .MISO(MISO),
        .ch_wr(ch_wr), .ch_addr(ch_addr), .ch_wdata(ch_wdata),
        .cmd_vld(cmd_vld), .cmd_ch(cmd_ch), .frm_err(frm_err)
    );

    always #5 clk = ~clk;

    // Count high cycles, so a stretched pulse shows up as an extra count.
    always @(negedge clk) begin
        if (cmd_vld) vld_cnt++;
        if (frm_err) err_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) chan_m[i] = 12'h000;
        ptr_m = 3'd0;
        cmd_ch_m = 3'd0;
    endtask

    task automatic wr_chan(input logic [2:0] a, input logic [11:0] d);
        ch_addr = a; ch_wdata = d; ch_wr = 1'b1;
        @(negedge clk);
        ch_wr = 1'b0;
        chan_m[a] = d;
    endtask

    // One SPI frame of nbits clocks; optional channel write or reset during bit wr_bit / rst_bit.
    task automatic frame(input string tag, input logic [15:0] cmd, input int nbits,
                         input int wr_bit, input logic [2:0] wa, input logic [11:0] wd,
                         input int rst_bit);
        logic [15:0] got, exp;
        int v0, e0;
        bit good;
        got = 16'h0;
        exp = {4'h0, chan_m[ptr_m]};
        v0 = vld_cnt; e0 = err_cnt;
        SS_n = 1'b0;
        repeat (4) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            SCLK = 1'b0;
            MOSI = (i < 16) ? cmd[15-i] : 1'b0;
            repeat (8) @(negedge clk);
            SCLK = 1'b1;
            if (i < 16) got[15-i] = MISO;
            for (int c = 0; c < 8; c++) begin
                if (c == 1 && i == wr_bit) begin
                    ch_addr = wa; ch_wdata = wd; ch_wr = 1'b1;
                    chan_m[wa] = wd;
                end
                if (c == 1 && i == rst_bit) begin
                    rst_n = 1'b0;
                    model_reset();
                end
                @(negedge clk);
                ch_wr = 1'b0;
                rst_n = 1'b1;
            end
        end
        repeat (4) @(negedge clk);
        SS_n = 1'b1;
        repeat (8) @(negedge clk);
        for (int i = 0; i < 16; i++) begin
            if (i >= nbits || (rst_bit >= 0 && i > rst_bit)) exp[15-i] = 1'b0;
        end
        chk({tag, ".miso"}, 32'(got), 32'(exp));
        chk({tag, ".idle_miso"}, 32'(MISO), 32'd0);
        if (rst_bit >= 0 && rst_bit < nbits) begin
            chk({tag, ".vld_pulses"}, 32'(vld_cnt - v0), 32'd0);
            chk({tag, ".err_pulses"}, 32'(err_cnt - e0), 32'd0);
        end else begin
            good = (nbits == 16) && (cmd[15:14] == 2'b00);
            if (good) begin
                ptr_m = cmd[13:11];
                cmd_ch_m = cmd[13:11];
            end
            chk({tag, ".vld_pulses"}, 32'(vld_cnt - v0), good ? 32'd1 : 32'd0);
            chk({tag, ".err_pulses"}, 32'(err_cnt - e0), good ? 32'd0 : 32'd1);
        end
        chk({tag, ".cmd_ch"}, 32'(cmd_ch), 32'(cmd_ch_m));
        repeat (4) @(negedge clk);
    endtask

    initial begin
        logic [15:0] rc;
        int nb, wb;
        model_reset();
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("rst.cmd_vld", 32'(cmd_vld), 32'd0);
        chk("rst.frm_err", 32'(frm_err), 32'd0);
        chk("rst.cmd_ch", 32'(cmd_ch), 32'd0);
        chk("rst.miso", 32'(MISO), 32'd0);

        wr_chan(3'd0, 12'hA5C);
        wr_chan(3'd4, 12'h3F1);
        wr_chan(3'd6, 12'h7B2);
        frame("ch4_cmd", 16'h2000, 16, -1, 3'd0, 12'h0, -1);
        frame("ch0_cmd", 16'h0000, 16, -1, 3'd0, 12'h0, -1);
        frame("ch6_cmd", 16'h3000, 16, -1, 3'd0, 12'h0, -1);
        frame("ch6_ret", 16'h0000, 16, -1, 3'd0, 12'h0, -1);
        frame("short9", 16'h2000, 9, -1, 3'd0, 12'h0, -1);
        frame("after_short", 16'h0000, 16, -1, 3'd0, 12'h0, -1);
        frame("long20", 16'h2000, 20, -1, 3'd0, 12'h0, -1);
        frame("bad_hdr", 16'hC000, 16, -1, 3'd0, 12'h0, -1);
        frame("bad_hdr_ret", 16'h2000, 16, -1, 3'd0, 12'h0, -1);
        frame("midwr", 16'h2000, 16, 5, 3'd4, 12'hFFF, -1);
        frame("midwr_ret", 16'h0000, 16, -1, 3'd0, 12'h0, -1);
        frame("rst_mid", 16'h3000, 16, -1, 3'd0, 12'h0, 7);
        wr_chan(3'd0, 12'h123);
        wr_chan(3'd6, 12'h456);
        frame("post_rst", 16'h3000, 16, -1, 3'd0, 12'h0, -1);
        frame("post_rst2", 16'h0000, 16, -1, 3'd0, 12'h0, -1);

        for (int n = 0; n < 24; n++) begin
            if ($urandom_range(0, 2) == 0) wr_chan(3'($urandom_range(0, 7)), 12'($urandom));
            rc = 16'($urandom);
            if ($urandom_range(0, 4) != 0) rc[15:14] = 2'b00;
            nb = ($urandom_range(0, 3) != 0) ? 16 : int'($urandom_range(1, 20));
            wb = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : -1;
            frame("rand", rc, nb, wb, 3'($urandom_range(0, 7)), 12'($urandom), -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #20ms;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
